// File: rtl/ysyx_24090003_pkg.sv
// Shared constants and helpers for the ysyx_24090003 register file slice.
package ysyx_24090003_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_IDX  = 0;

  // Constant-foldable ceil(log2(n)) for flows without a reliable $clog2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ysyx_24090003_regfile_sb_if.sv
// Bus between ID/WB stages and the scoreboarded register file.
interface ysyx_24090003_regfile_sb_if
  import ysyx_24090003_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = clog2(NREGS)
);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  // alloc_en/alloc_ready are valid/ready: a reservation is taken on the rising
  // edge where both are high; alloc_en while alloc_ready is low is a protocol error.
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                alloc_ready;
  logic [NREGS-1:0]    busy_vec;
  logic                sb_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, alloc_ready, busy_vec, sb_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, alloc_ready, busy_vec, sb_err
  );

endinterface

// File: rtl/ysyx_24090003_sb_cnt.sv
// Pending-write counter for one architectural register.
module ysyx_24090003_sb_cnt #(
  parameter int PEND_W = 2
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [PEND_W-1:0] o_cnt,
  output logic              o_full,
  output logic              o_err
);

  logic [PEND_W-1:0] r_cnt;

  // Simultaneous inc and dec cancel; saturation is prevented upstream.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + PEND_W'(1);
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - PEND_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_full = &r_cnt;
  assign o_err  = i_dec & ~i_inc & (r_cnt == '0);

endmodule

// File: rtl/ysyx_24090003_regfile_sb.sv
// Parametrised register file with per-register pending-write scoreboard.
module ysyx_24090003_regfile_sb
  import ysyx_24090003_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int PEND_W   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic                       cpu_clk,
  input logic                       cpu_rst,
  ysyx_24090003_regfile_sb_if.slave bus
);

  localparam int            AW     = clog2(NREGS);
  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_IDX);

  logic [XLEN-1:0]   r_regs [NREGS];
  logic              r_sb_err;
  logic [PEND_W-1:0] w_cnt  [NREGS];
  logic [NREGS-1:0]  w_full;
  logic [NREGS-1:0]  w_err_vec;
  logic [AW-1:0]     w_ra   [NRD];
  logic              w_wr_zero;
  logic              w_alloc_zero;
  logic              w_wr_fire;
  logic              w_alloc_ready;
  logic              w_alloc_fire;

  assign w_wr_zero     = (ZERO_REG != 0) && (bus.wr_addr == ZERO_A);
  assign w_alloc_zero  = (ZERO_REG != 0) && (bus.alloc_addr == ZERO_A);
  assign w_wr_fire     = bus.wr_en & ~w_wr_zero;
  // A writeback releasing the same register this cycle frees the full slot.
  assign w_alloc_ready = w_alloc_zero | ~w_full[bus.alloc_addr] |
                         (w_wr_fire & (bus.wr_addr == bus.alloc_addr));
  assign w_alloc_fire  = bus.alloc_en & w_alloc_ready & ~w_alloc_zero;

  for (genvar g = 0; g < NREGS; g++) begin : g_cnt
    ysyx_24090003_sb_cnt #(.PEND_W(PEND_W)) u_cnt (
      .cpu_clk (cpu_clk),
      .cpu_rst (cpu_rst),
      .i_inc   (w_alloc_fire && (bus.alloc_addr == AW'(g))),
      .i_dec   (w_wr_fire && (bus.wr_addr == AW'(g))),
      .o_cnt   (w_cnt[g]),
      .o_full  (w_full[g]),
      .o_err   (w_err_vec[g])
    );
    assign bus.busy_vec[g] = |w_cnt[g];
  end

  for (genvar g = 0; g < NRD; g++) begin : g_ra
    assign w_ra[g] = bus.rd_addr[g*AW +: AW];
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else if (w_wr_fire) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_sb_err <= 1'b0;
    end else if ((|w_err_vec) || (bus.alloc_en && !w_alloc_ready)) begin
      r_sb_err <= 1'b1;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if ((ZERO_REG != 0) && (w_ra[i] == ZERO_A)) begin
        bus.rd_data[i*XLEN +: XLEN] = '0;
        bus.rd_busy[i]              = 1'b0;
      end else begin
        if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == w_ra[i])) begin
          bus.rd_data[i*XLEN +: XLEN] = bus.wr_data;
        end else begin
          bus.rd_data[i*XLEN +: XLEN] = r_regs[w_ra[i]];
        end
        // The last outstanding write landing this cycle satisfies the reader.
        bus.rd_busy[i] = (w_cnt[w_ra[i]] > PEND_W'(1)) ||
                         ((w_cnt[w_ra[i]] == PEND_W'(1)) &&
                          !((BYPASS != 0) && w_wr_fire && (bus.wr_addr == w_ra[i])));
      end
    end
  end

  assign bus.alloc_ready = w_alloc_ready;
  assign bus.sb_err      = r_sb_err;

endmodule

// File: tb/tb_ysyx_24090003_regfile_sb.sv
// Randomised and directed scoreboard bench for the register file, 3-port 64-bit config.
module tb_ysyx_24090003_regfile_sb;

  localparam int XLEN   = 64;
  localparam int NREGS  = 16;
  localparam int NRD    = 3;
  localparam int PEND_W = 2;
  localparam int AW     = 4;
  localparam int CMAX   = (1 << PEND_W) - 1;

  typedef struct packed {
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
    logic                ready;
    logic [NREGS-1:0]    bvec;
    logic                err;
  } exp_t;

  logic cpu_clk;
  logic cpu_rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  logic [XLEN-1:0] m_reg [NREGS];
  int              m_cnt [NREGS];
  bit              m_err;

  ysyx_24090003_regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  ysyx_24090003_regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .PEND_W(PEND_W), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  // clock / reset
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string nm, input logic [NRD*XLEN-1:0] act, input logic [NRD*XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Driver: applies one cycle of inputs at the falling edge, predicts outputs, advances the model.
  task automatic step(input bit rst, input bit we, input int wa, input logic [XLEN-1:0] wd,
                      input bit ae, input int aa, input int r0, input int r1, input int r2);
    exp_t e;
    int   ra [NRD];
    bit   wf;
    bit   af;
    @(negedge cpu_clk);
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    cpu_rst        = rst;
    bus.wr_en      = we;
    bus.wr_addr    = AW'(wa);
    bus.wr_data    = wd;
    bus.alloc_en   = ae;
    bus.alloc_addr = AW'(aa);
    bus.rd_addr    = {AW'(r2), AW'(r1), AW'(r0)};
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_reg[r] = '0;
        m_cnt[r] = 0;
      end
      m_err = 1'b0;
    end
    wf = we && (wa != 0);
    e = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ra[i] == 0)                e.data[i*XLEN +: XLEN] = '0;
      else if (we && (wa == ra[i]))  e.data[i*XLEN +: XLEN] = wd;
      else                           e.data[i*XLEN +: XLEN] = m_reg[ra[i]];
      e.busy[i] = (ra[i] != 0) &&
                  ((m_cnt[ra[i]] >= 2) || ((m_cnt[ra[i]] == 1) && !(wf && (wa == ra[i]))));
    end
    e.ready = (aa == 0) || (m_cnt[aa] < CMAX) || (wf && (wa == aa));
    for (int r = 0; r < NREGS; r++) e.bvec[r] = (m_cnt[r] != 0);
    e.err = m_err;
    exp_q.push_back(e);
    if (!rst) begin
      if (ae && !e.ready) m_err = 1'b1;
      af = ae && e.ready && (aa != 0);
      if (wf) m_reg[wa] = wd;
      if (!(af && wf && (aa == wa))) begin
        if (af) m_cnt[aa] = m_cnt[aa] + 1;
        if (wf) begin
          if (m_cnt[wa] == 0) m_err = 1'b1;
          else                m_cnt[wa] = m_cnt[wa] - 1;
        end
      end
    end
  endtask

  task automatic idle(input int r0, input int r1, input int r2);
    step(0, 0, 0, '0, 0, 0, r0, r1, r2);
  endtask

  task automatic alloc(input int aa);
    step(0, 0, 0, '0, 1, aa, aa, 0, 0);
  endtask

  // Monitor: samples between edges and checks against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge cpu_clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data",     bus.rd_data,     e.data);
        chk("rd_busy",     bus.rd_busy,     e.busy);
        chk("alloc_ready", bus.alloc_ready, e.ready);
        chk("busy_vec",    bus.busy_vec,    e.bvec);
        chk("sb_err",      bus.sb_err,      e.err);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    cpu_rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.alloc_en = 1'b0; bus.alloc_addr = '0; bus.rd_addr = '0;

    // reset, bypass, hardwired zero
    step(1, 0, 0, '0, 0, 0, 5, 0, 0);
    idle(5, 1, 2);
    step(0, 1, 5, 64'hDEADBEEF, 0, 0, 5, 0, 0);
    idle(5, 0, 5);
    step(0, 1, 0, 64'h1234, 0, 0, 0, 5, 0);
    idle(0, 5, 0);

    // saturation of r7, error on over-alloc, release frees slot
    step(1, 0, 0, '0, 0, 0, 0, 0, 0);
    alloc(7); alloc(7); alloc(7);
    step(0, 0, 0, '0, 1, 7, 7, 7, 0);
    step(0, 1, 7, 64'h77, 1, 7, 7, 0, 0);
    idle(7, 0, 0);

    // last-write bypass clears busy; two pending keeps it busy
    step(1, 0, 0, '0, 0, 0, 0, 0, 0);
    alloc(3);
    step(0, 1, 3, 64'h55, 0, 0, 0, 3, 0);
    idle(0, 3, 0);
    alloc(3); alloc(3);
    step(0, 1, 3, 64'h66, 0, 0, 0, 3, 0);
    idle(3, 3, 3);

    // writeback with nothing pending: sticky error
    step(1, 0, 0, '0, 0, 0, 0, 0, 0);
    step(0, 1, 9, 64'h99, 0, 0, 9, 0, 0);
    for (int k = 0; k < 10; k++) idle(9, 0, 0);

    // asynchronous reset between edges
    step(1, 0, 0, '0, 0, 0, 0, 0, 0);
    alloc(4); alloc(4); alloc(4);
    step(0, 1, 4, 64'hAA, 0, 0, 4, 0, 0);
    idle(4, 0, 0);
    step(1, 0, 0, '0, 0, 0, 4, 4, 4);
    idle(4, 0, 0);

    // three ports, 64-bit data, concurrent alloc and writeback
    step(0, 1, 1, 64'h1111_2222_3333_4444, 0, 0, 0, 0, 0);
    step(0, 1, 2, 64'h5555_6666_7777_8888, 0, 0, 1, 0, 0);
    step(0, 1, 15, 64'h9999_AAAA_BBBB_CCCC, 0, 0, 1, 2, 0);
    idle(1, 2, 15);
    step(1, 0, 0, '0, 0, 0, 1, 2, 15);
    alloc(1);
    step(0, 1, 1, 64'hF0F0_0F0F_1234_5678, 1, 2, 1, 2, 15);
    idle(1, 2, 15);

    // randomised traffic with occasional reset
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, NREGS - 1),
           {$urandom, $urandom}, ($urandom_range(0, 1) != 0), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, NREGS - 1), $urandom_range(0, 3));
    end

    @(negedge cpu_clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d predictions left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
